// File: rtl/cnn_accel_pkg.sv
// Shared types and sizing helpers for the CNN accelerator result reader.
package cnn_accel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_EMIT,
    ST_DONE
  } state_e;

  function automatic int unsigned num_words(input int unsigned bus_w, input int unsigned data_w);
    return bus_w / data_w;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned max_size);
    return $clog2(max_size) + 1;
  endfunction

  function automatic int unsigned lane_w(input int unsigned nw);
    return (nw > 1) ? $clog2(nw) : 1;
  endfunction

  localparam int unsigned NUM_WORDS = num_words(64, 32);
  localparam int unsigned CNT_W     = cnt_w(4096);
  localparam int unsigned LANE_W    = lane_w(NUM_WORDS);

endpackage

// File: rtl/bus_word_unpacker.sv
// Lane buffer(s) that turn loaded bus words into a valid/ready/last result stream.
// With PREFETCH set, two buffers form a ping-pong FIFO so loading overlaps emission.
module bus_word_unpacker
  import cnn_accel_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WORDS  = 2,
  parameter int unsigned LANE_W     = 1,
  parameter bit          PREFETCH   = 1'b0
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              load_i,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0]   word_i,
  input  logic [LANE_W-1:0]                 last_lane_i,
  input  logic                              final_i,
  input  logic                              ready_i,
  output logic [DATA_WIDTH-1:0]             data_o,
  output logic                              valid_o,
  output logic                              last_o,
  output logic                              free_o
);

  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] word_q [2];
  logic [LANE_W-1:0]                    lastl_q [2];
  logic [1:0]                           fin_q;
  logic [1:0]                           full_q, full_d;
  logic                                 rd_q, wr_q;
  logic [LANE_W-1:0]                    lane_q;
  logic                                 hs, at_last_lane, drain;

  assign valid_o      = full_q[rd_q];
  assign data_o       = word_q[rd_q][lane_q];
  assign at_last_lane = (lane_q == lastl_q[rd_q]);
  assign last_o       = valid_o & fin_q[rd_q] & at_last_lane;
  assign hs           = valid_o & ready_i;
  assign drain        = hs & at_last_lane;

  // Occupancy after this edge, so the FSM can issue a read that lands in a buffer freed now.
  always_comb begin
    full_d = full_q;
    if (drain)  full_d[rd_q] = 1'b0;
    if (load_i) full_d[wr_q] = 1'b1;
  end

  assign free_o = ~full_d[0] | (PREFETCH & ~full_d[1]);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < 2; i++) begin
        word_q[i]  <= '0;
        lastl_q[i] <= '0;
      end
      fin_q  <= '0;
      full_q <= '0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      lane_q <= '0;
    end else begin
      full_q <= full_d;
      if (hs) lane_q <= drain ? '0 : lane_q + 1'b1;
      if (drain && PREFETCH) rd_q <= ~rd_q;
      if (load_i) begin
        word_q[wr_q]  <= word_i;
        lastl_q[wr_q] <= last_lane_i;
        fin_q[wr_q]   <= final_i;
        if (PREFETCH) wr_q <= ~wr_q;
      end
    end
  end

endmodule

// File: rtl/cnn_result_reader.sv
// Reads a block of packed results from bus memory and streams them out lane 0 first.
// Define CNN_RESULT_READER_PREFETCH_EN for a ping-pong buffer that overlaps reads with emission.
module cnn_result_reader
  import cnn_accel_pkg::*;
#(
  parameter int unsigned BUS_ADDR_WIDTH = 32,
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MAX_SIZE       = 4096
) (
  input  logic                          clkIn,
  input  logic                          rstIn,
  input  logic                          startIn,
  input  logic [BUS_ADDR_WIDTH-1:0]     baseAddrIn,
  input  logic [cnt_w(MAX_SIZE)-1:0]    numWordsIn,
  output logic                          rdEnOut,
  output logic [BUS_ADDR_WIDTH-1:0]     addrOut,
  input  logic [BUS_DATA_WIDTH-1:0]     rdDataIn,
  output logic [DATA_WIDTH-1:0]         dataOut,
  output logic                          validOut,
  output logic                          lastOut,
  input  logic                          readyIn,
  output logic                          busyOut,
  output logic                          doneOut
);

  localparam int unsigned NW = num_words(BUS_DATA_WIDTH, DATA_WIDTH);
  localparam int unsigned CW = cnt_w(MAX_SIZE);
  localparam int unsigned LW = lane_w(NW);
`ifdef CNN_RESULT_READER_PREFETCH_EN
  localparam bit PREFETCH = 1'b1;
`else
  localparam bit PREFETCH = 1'b0;
`endif

  state_e                    state_q, state_d;
  logic [BUS_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]             toread_q, toread_d;
  logic [CW-1:0]             take;
  logic                      final_word, load, buf_free;

  // toread counts results not yet loaded; the word in flight carries min(toread, NW) lanes.
  assign final_word = (toread_q <= CW'(NW));
  assign take       = final_word ? toread_q : CW'(NW);
  assign load       = (state_q == ST_WAIT);

  bus_word_unpacker #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_WORDS  (NW),
    .LANE_W     (LW),
    .PREFETCH   (PREFETCH)
  ) u_unpacker (
    .clk_i       (clkIn),
    .rst_ni      (rstIn),
    .load_i      (load),
    .word_i      (rdDataIn),
    .last_lane_i (LW'(take - 1'b1)),
    .final_i     (final_word),
    .ready_i     (readyIn),
    .data_o      (dataOut),
    .valid_o     (validOut),
    .last_o      (lastOut),
    .free_o      (buf_free)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    toread_d = toread_q;
    rdEnOut  = 1'b0;
    addrOut  = '0;
    busyOut  = 1'b0;
    doneOut  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (startIn) begin
          addr_d   = baseAddrIn;
          toread_d = numWordsIn;
          state_d  = (numWordsIn != '0) ? ST_READ : ST_DONE;
        end
      end
      ST_READ: begin
        busyOut = 1'b1;
        rdEnOut = 1'b1;
        addrOut = addr_q;
        addr_d  = addr_q + 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        busyOut  = 1'b1;
        toread_d = toread_q - take;
        state_d  = ((toread_d != '0) && buf_free) ? ST_READ : ST_EMIT;
      end
      ST_EMIT: begin
        busyOut = 1'b1;
        if (lastOut && readyIn)                     state_d = ST_DONE;
        else if ((toread_q != '0) && buf_free)      state_d = ST_READ;
      end
      ST_DONE: begin
        doneOut = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkIn) begin
    if (!rstIn) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      toread_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      toread_q <= toread_d;
    end
  end

endmodule

// File: tb/tb_cnn_result_reader.sv
// Directed bench for cnn_result_reader: bus memory model, stream monitor, hand-computed expectations.
module tb_cnn_result_reader;

  logic        clk = 1'b0;
  logic        rstIn, startIn, readyIn;
  logic [31:0] baseAddrIn;
  logic [12:0] numWordsIn;
  logic        rdEnOut;
  logic [31:0] addrOut;
  logic [63:0] rdDataIn;
  logic [31:0] dataOut;
  logic        validOut, lastOut, busyOut, doneOut;

  cnn_result_reader #(
    .BUS_ADDR_WIDTH (32),
    .BUS_DATA_WIDTH (64),
    .DATA_WIDTH     (32),
    .MAX_SIZE       (4096)
  ) dut (
    .clkIn      (clk),
    .rstIn      (rstIn),
    .startIn    (startIn),
    .baseAddrIn (baseAddrIn),
    .numWordsIn (numWordsIn),
    .rdEnOut    (rdEnOut),
    .addrOut    (addrOut),
    .rdDataIn   (rdDataIn),
    .dataOut    (dataOut),
    .validOut   (validOut),
    .lastOut    (lastOut),
    .readyIn    (readyIn),
    .busyOut    (busyOut),
    .doneOut    (doneOut)
  );

  always #5 clk = ~clk;

`ifdef CNN_RESULT_READER_PREFETCH_EN
  localparam bit PREF = 1'b1;
`else
  localparam bit PREF = 1'b0;
`endif

  int n_vec = 0;
  int n_bad = 0;

  logic [63:0] mem [64];
  int          cyc = 0;
  logic [31:0] beat_q[$];
  logic        last_q[$];
  int          hs_cyc[$];
  logic [31:0] addr_log[$];
  int          first_rd, first_val, done_cnt, done_cyc, stall_err, valid_cnt;
  bit          toggle_mode = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;
  bit          rd_pend = 1'b0;
  logic [5:0]  pend_addr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor and bus responder: everything sampled mid-cycle, on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (prev_stall && (!validOut || dataOut !== prev_data || lastOut !== prev_last)) stall_err++;
    readyIn = toggle_mode ? ~readyIn : 1'b1;
    if (rdEnOut) begin
      addr_log.push_back(addrOut);
      if (first_rd < 0) first_rd = cyc;
    end
    if (validOut) begin
      valid_cnt++;
      if (first_val < 0) first_val = cyc;
    end
    if (validOut && readyIn) begin
      beat_q.push_back(dataOut);
      last_q.push_back(lastOut);
      hs_cyc.push_back(cyc);
    end
    if (doneOut) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_stall = validOut && !readyIn && rstIn;
    prev_data  = dataOut;
    prev_last  = lastOut;
    rdDataIn   = rd_pend ? mem[pend_addr] : {$urandom, $urandom};
    rd_pend    = rdEnOut;
    pend_addr  = addrOut[5:0];
  end

  task automatic clear_logs();
    beat_q.delete(); last_q.delete(); hs_cyc.delete(); addr_log.delete();
    first_rd = -1; first_val = -1; done_cnt = 0; done_cyc = -1;
    stall_err = 0; valid_cnt = 0; prev_stall = 1'b0;
  endtask

  task automatic start_xfer(input logic [31:0] base, input logic [12:0] num, input bit tog,
                            output int c);
    clear_logs();
    toggle_mode = tog;
    @(negedge clk); #1;
    startIn = 1'b1; baseAddrIn = base; numWordsIn = num;
    c = cyc;
    @(negedge clk); #1;
    startIn = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_done"}, 64'(done_cnt), 64'd1);
  endtask

  task automatic check_stream(input string tag, input logic [31:0] v0, input int n);
    check({tag, "_nbeats"}, 64'(beat_q.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", tag, i), 64'(beat_q[i]), 64'(v0 + 32'(i)));
      check($sformatf("%s_last%0d", tag, i), 64'(last_q[i]), 64'(i == n - 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    logic [31:0] lo;
    rstIn = 1'b0; startIn = 1'b0; readyIn = 1'b1;
    baseAddrIn = '0; numWordsIn = '0; rdDataIn = '0;
    for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom};
    mem[0] = 64'h0000_0002_0000_0001;
    mem[1] = 64'h0000_0004_0000_0003;
    for (int i = 0; i < 4; i++) begin
      lo = 32'h1000 + 32'(2 * i);
      mem[16 + i] = {lo + 32'd1, lo};
    end
    for (int i = 0; i < 8; i++) begin
      lo = 32'h2000 + 32'(2 * i);
      mem[32 + i] = {lo + 32'd1, lo};
    end
    mem[48] = 64'h0000_3001_0000_3000;
    clear_logs();

    repeat (3) @(negedge clk);
    #1;
    check("rst_ctrl", 64'({validOut, lastOut, busyOut, doneOut, rdEnOut}), 64'd0);
    check("rst_data", 64'(dataOut), 64'd0);
    check("rst_addr", 64'(addrOut), 64'd0);
    rstIn = 1'b1;

    // 1: two full words, latency and done timing
    start_xfer(32'h0, 13'd4, 1'b0, c);
    wait_done("t1", 100);
    check_stream("t1", 32'd1, 4);
    check("t1_nrd", 64'(addr_log.size()), 64'd2);
    check("t1_rd_lat", 64'(first_rd), 64'(c + 1));
    check("t1_val_lat", 64'(first_val), 64'(c + 3));
    check("t1_done_cyc", 64'(done_cyc), 64'(hs_cyc[3] + 1));

    // 2: partial final word, upper lane discarded
    start_xfer(32'h0, 13'd3, 1'b0, c);
    wait_done("t2", 100);
    check_stream("t2", 32'd1, 3);
    check("t2_nrd", 64'(addr_log.size()), 64'd2);

    // 3: empty transfer
    start_xfer(32'h0, 13'd0, 1'b0, c);
    wait_done("t3", 20);
    check("t3_done_cyc", 64'(done_cyc), 64'(c + 1));
    check("t3_nrd", 64'(addr_log.size()), 64'd0);
    check("t3_nvalid", 64'(valid_cnt), 64'd0);

    // 4: readyIn toggling every cycle
    start_xfer(32'h10, 13'd8, 1'b1, c);
    wait_done("t4", 200);
    check_stream("t4", 32'h1000, 8);
    check("t4_nrd", 64'(addr_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) check($sformatf("t4_addr%0d", i), 64'(addr_log[i]), 64'(32'h10 + 32'(i)));
    check("t4_stall", 64'(stall_err), 64'd0);
    toggle_mode = 1'b0;

    // 5: reset during EMIT after two beats, then a fresh transfer
    start_xfer(32'h10, 13'd8, 1'b0, c);
    for (int n = 0; n < 100 && beat_q.size() < 2; n++) begin
      @(negedge clk); #1;
    end
    check("t5_beats_pre", 64'(beat_q.size()), 64'd2);
    rstIn = 1'b0;
    @(negedge clk); #1;
    check("t5_rst_ctrl", 64'({validOut, lastOut, busyOut, doneOut, rdEnOut}), 64'd0);
    check("t5_rst_data", 64'({dataOut, addrOut}), 64'd0);
    rstIn = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("t5_no_done", 64'(done_cnt), 64'd0);
    start_xfer(32'h30, 13'd2, 1'b0, c);
    wait_done("t5b", 100);
    check_stream("t5b", 32'h3000, 2);
    check("t5b_addr", 64'(addr_log[0]), 64'h30);

    // 6: long transfer, throughput, start pulse while busy ignored
    start_xfer(32'h20, 13'd16, 1'b0, c);
    repeat (2) @(negedge clk);
    #1;
    startIn = 1'b1; baseAddrIn = 32'h3F; numWordsIn = 13'd1;
    @(negedge clk); #1;
    startIn = 1'b0;
    wait_done("t6", 300);
    repeat (5) @(negedge clk);
    #1;
    check_stream("t6", 32'h2000, 16);
    check("t6_nrd", 64'(addr_log.size()), 64'd8);
    for (int i = 0; i < 8; i++) check($sformatf("t6_addr%0d", i), 64'(addr_log[i]), 64'(32'h20 + 32'(i)));
    for (int i = 1; i < 16; i++)
      check($sformatf("t6_gap%0d", i), 64'(hs_cyc[i] - hs_cyc[i - 1]),
            64'((PREF || (i % 2 == 1)) ? 1 : 3));
    check("t6_done_cnt", 64'(done_cnt), 64'd1);
    check("t6_done_cyc", 64'(done_cyc), 64'(hs_cyc[15] + 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
